// File: rtl/irq_controller_if.sv
// CPU-side bus of the priority interrupt controller: register access plus INT/intack.
interface irq_controller_if;
    logic [11:0] address;
    logic [15:0] data_out;
    logic        memwt;
    logic        intack;
    logic        INT;
    logic [15:0] vector;
    logic [15:0] rd_data;
    logic        rd_hit;

    modport master (
        output address, data_out, memwt, intack,
        input  INT, vector, rd_data, rd_hit
    );

    modport slave (
        input  address, data_out, memwt, intack,
        output INT, vector, rd_data, rd_hit
    );
endinterface

// File: rtl/irq_controller.sv
// Programmable priority interrupt controller: edge-latched requests, mask, INT/intack/EOI handshake.
// Define NESTED_IRQ_EN to allow higher-priority sources to preempt a source in service.
module irq_controller #(
    parameter int          NUM_IRQ      = 8,
    parameter logic [11:0] BASE_ADDR    = 12'hA00,
    parameter logic [15:0] SPURIOUS_VEC = 16'h0007
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    irq_controller_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] insvc_q, insvc_d;
    logic [2:0]         grant_q, grant_d;

    logic [NUM_IRQ-1:0] edge_det, req, grant_oh, ack_clr, isv_clr;
    logic [11:0]        offset;
    logic               wr_mask, wr_eoi;
    logic [2:0]         win_idx;
    logic               int_o;
    logic [15:0]        vector_o, rd_data_o;
    logic               unused_data;

    // Lowest set index wins; irq0 is highest priority.
    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    assign edge_det = irq & ~irq_q;
    assign req      = pending_q & ~mask_q;
    assign win_idx  = lowest_idx(req);
    assign grant_oh = NUM_IRQ'(1) << grant_q;

    assign offset      = bus.address - BASE_ADDR;
    assign bus.rd_hit  = (offset < 12'd4);
    assign wr_mask     = bus.memwt && bus.rd_hit && (offset[1:0] == 2'd0);
    assign wr_eoi      = bus.memwt && bus.rd_hit && (offset[1:0] == 2'd2);
    assign unused_data = ^bus.data_out[15:NUM_IRQ];

`ifdef NESTED_IRQ_EN
    logic [2:0]         isv_lo;
    logic [NUM_IRQ-1:0] isv_lo_oh;
    assign isv_lo    = lowest_idx(insvc_q);
    assign isv_lo_oh = NUM_IRQ'(1) << isv_lo;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_clr  = '0;
        isv_clr  = '0;
        int_o    = 1'b0;
        vector_o = 16'h0000;
        unique case (state_q)
            IDLE: begin
                if (bus.intack) vector_o = SPURIOUS_VEC;
                if (req != '0) begin
                    grant_d = win_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                int_o = 1'b1;
                if (bus.intack) begin
                    vector_o = 16'(grant_q);
                    ack_clr  = grant_oh;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (bus.intack) vector_o = 16'(grant_q);
                else            state_d  = SERVICE;
            end
            SERVICE: begin
                if (bus.intack) vector_o = SPURIOUS_VEC;
`ifdef NESTED_IRQ_EN
                // The active level is always the lowest set in_service bit.
                if (wr_eoi) begin
                    isv_clr = isv_lo_oh;
                    state_d = ((insvc_q & ~isv_lo_oh) != '0) ? SERVICE : IDLE;
                end else if (req != '0 && win_idx < isv_lo) begin
                    grant_d = win_idx;
                    state_d = REQ;
                end
`else
                if (wr_eoi) begin
                    isv_clr = grant_oh;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge on a bit being acknowledged keeps it pending (set wins).
    assign pending_d = (pending_q & ~ack_clr) | edge_det;
    assign insvc_d   = (insvc_q & ~isv_clr) | ack_clr;
    assign mask_d    = wr_mask ? bus.data_out[NUM_IRQ-1:0] : mask_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            insvc_q   <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            insvc_q   <= insvc_d;
            grant_q   <= grant_d;
        end
    end

    always_comb begin
        rd_data_o = 16'h0000;
        if (bus.rd_hit) begin
            unique case (offset[1:0])
                2'd0:    rd_data_o = 16'(mask_q);
                2'd1:    rd_data_o = 16'(pending_q);
                2'd3:    rd_data_o = 16'(insvc_q);
                default: rd_data_o = 16'h0000;
            endcase
        end
    end

    assign bus.INT     = int_o;
    assign bus.vector  = vector_o;
    assign bus.rd_data = rd_data_o;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Programmable priority interrupt controller between peripheral irq lines and the mammal CPU's INT/intack pins.
- Replaces the fixed combinational irq priority mux in the top level.
- Latches edge-triggered requests, applies a CPU-writable mask and drives INT.
- Returns the winning vector on intack and holds further interrupts until the CPU writes end-of-interrupt (EOI).
- Memory-mapped on the CPU's 12-bit address bus.

Parameters:
NUM_IRQ, 8, number of irq inputs (1..8); irq0 is highest priority
BASE_ADDR, 12'hA00, base of register window (MASK=BASE, PENDING=BASE+1, EOI=BASE+2, INSERVICE=BASE+3)
SPURIOUS_VEC, 16'h0007, vector returned when intack arrives with nothing granted

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
irq  input  NUM_IRQ  peripheral request lines, rising-edge sensitive, synchronous to clk
address  input  12  CPU address bus
data_out  input  16  CPU write data
memwt  input  1  CPU write strobe
intack  input  1  CPU interrupt acknowledge
INT  output  1  interrupt request to CPU
vector  output  16  interrupt vector, valid while intack=1
rd_data  output  16  register read data for the top-level input mux
rd_hit  output  1  1 when address is in BASE..BASE+3; top level selects rd_data

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, mask=all ones (all masked), in_service=0, irq_q=0, FSM=IDLE, INT=0, vector=0.
- Edge detect: irq_q registers irq each cycle. pending[i] is set on the cycle irq[i]=1 and irq_q[i]=0. Edges latch regardless of mask.
- Request vector: req = pending & ~mask. Winner = lowest set index of req.
- FSM IDLE: if req!=0, latch winner into grant_idx and go to REQ. INT=1 from the cycle after the edge is latched (2 clk after the irq rising edge).
- FSM REQ: INT=1. Winner is frozen; a higher-priority edge arriving now waits. intack=1 goes to ACK.
- FSM ACK: vector = {12'b0, grant_idx} combinationally while intack=1.
  - On the first ACK cycle: clear pending[grant_idx] and set in_service[grant_idx].
  - INT deasserts on entry to ACK.
  - intack=0 goes to SERVICE.
- FSM SERVICE: INT=0. A write to EOI clears in_service[grant_idx] and returns to IDLE. Re-arbitration happens the next cycle.
- Spurious intack (intack=1 in IDLE or SERVICE): vector=SPURIOUS_VEC; no state change.
- MASK write (memwt & address==BASE): mask <= data_out[NUM_IRQ-1:0], effective next cycle. Masking the granted source while in REQ does not withdraw INT; the grant completes.
- EOI write (BASE+2): data ignored. EOI outside SERVICE is ignored.
- PENDING and INSERVICE addresses are read-only; writes are ignored.
- Reads are combinational on address:
  - BASE returns mask.
  - BASE+1 returns pending.
  - BASE+3 returns in_service.
  - BASE+2 returns 0.
  - Unused high bits read 0.
  - rd_data=0 when rd_hit=0.
- Simultaneous edge on bit i and clear of pending[i] in the same cycle: set wins, so pending[i] stays 1.
- Held-high irq produces exactly one pending event until it falls and rises again.
- intack held more than 1 cycle: vector stays stable; pending is cleared only once.

Optional Feature:
- Macro: NESTED_IRQ_EN.
- Defined:
  - In SERVICE, a req winner of strictly higher priority than every in_service bit re-enters REQ and asserts INT.
  - in_service may hold multiple bits.
  - EOI clears the highest-priority (lowest index) in_service bit.
  - FSM returns to SERVICE if in_service is still nonzero after EOI, else to IDLE.
  - grant_idx is saved per level by deriving it from in_service.
- Undefined:
  - No preemption; at most one in_service bit is set.
  - Behaviour is exactly as above.

Test Plan:
- Reset, write MASK=8'hFB, pulse irq[2] -> INT=1 two cycles later; raise intack -> vector=16'h0002, PENDING reads 0, INSERVICE reads 8'h04; drop intack, write EOI -> INSERVICE reads 0, INT stays 0.
- Mask all (8'hFF), pulse irq[5] -> INT stays 0, PENDING=8'h20; write MASK=8'h00 -> INT=1 next cycle, vector on intack=16'h0005.
- irq[1] and irq[6] rise in the same cycle, MASK=0 -> first vector 16'h0001; after EOI, INT reasserts and second vector is 16'h0006.
- intack pulsed while IDLE -> vector=16'h0007, no register changes.
- Assert rst_n=0 mid-REQ with PENDING=8'h03 -> INT=0, PENDING=0, MASK reads 8'hFF immediately (asynchronous).
- NESTED_IRQ_EN build: in SERVICE for irq4, pulse irq[0] -> INT reasserts, vector=16'h0000, INSERVICE=8'h11; first EOI -> 8'h10; second EOI -> 8'h00. Non-nested build: same stimulus gives INT=0 until the EOI.
